// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte writer.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, BIT, ACKB, STOP, DONE} state_t;

  // Quarter-period phases within one bus slot.
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam int BYTES = 3;
  localparam int SLOTS = 29;

  // Bus pin levels for a given state/phase: returns {scl, sda_low}.
  // STOP p3 keeps SCL high so the bus is already idle when DONE is entered.
  function automatic logic [1:0] bus_pins(input state_t s, input logic [1:0] ph, input logic b);
    logic scl;
    logic low;
    scl = 1'b1;
    low = 1'b0;
    case (s)
      START: begin
        scl = (ph == P1) || (ph == P2);
        low = (ph == P2) || (ph == P3);
      end
      BIT: begin
        scl = (ph == P1) || (ph == P2);
        low = ~b;
      end
      ACKB: begin
        scl = (ph == P1) || (ph == P2);
        low = 1'b0;
      end
      STOP: begin
        scl = (ph != P0);
        low = (ph == P0) || (ph == P1);
      end
      default: begin
        scl = 1'b1;
        low = 1'b0;
      end
    endcase
    return {scl, low};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick divider: pulses tick every Q enabled cycles.
`timescale 1ns/1ps
module i2c_tick_gen #(
  parameter int Q = 5
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(Q);
  localparam logic [W-1:0] LAST = W'(Q - 1);

  logic [W-1:0] div_reg;

  // Divider counts 0..Q-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_reg <= '0;
    end else if (clr || !en) begin
      div_reg <= '0;
    end else if (div_reg == LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign tick = en && (div_reg == LAST);

endmodule

// File: rtl/i2c_byte_writer.sv
// I2C write master: sends {slave_addr, sub_addr, data} with START/STOP.
// Pins are registered from next-state values so SCL/SDA never glitch.
`timescale 1ns/1ps
module i2c_byte_writer import i2c_pkg::*; #(
  parameter int CLK_Freq = 50000000,
  parameter int I2C_Freq = 20000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iGO,
  input  logic [23:0] iDATA,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int Q = CLK_Freq / (4 * I2C_Freq);
  localparam logic [4:0] ALL_BITS = 5'(8 * BYTES);

  state_t      state_reg, state_next;
  logic [1:0]  phase_reg, phase_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [23:0] shift_reg, shift_next;
  logic        end_reg, end_next;
  logic        ack_reg, ack_next;
  logic        busy_reg, busy_next;
  logic        scl_reg, scl_next;
  logic        sda_low_reg, sda_low_next;
  logic        accept;
  logic        tick;
  logic        run;

  assign run = (state_reg == START) || (state_reg == BIT) ||
               (state_reg == ACKB)  || (state_reg == STOP);

  i2c_tick_gen #(.Q(Q)) u_tick (
    .iCLK (iCLK),
    .iRST (iRST),
    .clr  (accept),
    .en   (run),
    .tick (tick)
  );

  // State register; reset releases the bus immediately.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_reg   <= IDLE;
      phase_reg   <= P0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      end_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      scl_reg     <= 1'b1;
      sda_low_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      end_reg     <= end_next;
      ack_reg     <= ack_next;
      busy_reg    <= busy_next;
      scl_reg     <= scl_next;
      sda_low_reg <= sda_low_next;
    end
  end

  // Next-state, handshake and pin decode.
  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    end_next     = end_reg;
    ack_next     = ack_reg;
    busy_next    = busy_reg;
    accept       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (iGO && !end_reg) begin
          accept       = 1'b1;
          shift_next   = iDATA;
          busy_next    = 1'b1;
          ack_next     = 1'b0;
          phase_next   = P0;
          bit_cnt_next = '0;
          state_next   = START;
        end
      end
      START, BIT, ACKB, STOP: begin
        if (tick) begin
          phase_next = phase_reg + 2'd1;
          // ACK bit is sampled in the middle of the SCL-high window.
          if (state_reg == ACKB && phase_reg == P1 && I2C_SDAT == 1'b1) begin
            ack_next = 1'b1;
          end
          if (phase_reg == P3) begin
            if (state_reg == START) begin
              state_next = BIT;
            end else if (state_reg == BIT) begin
              shift_next   = {shift_reg[22:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + 5'd1;
              if (bit_cnt_reg[2:0] == 3'd7) begin
                state_next = ACKB;
              end
            end else if (state_reg == ACKB) begin
              state_next = (bit_cnt_reg == ALL_BITS) ? STOP : BIT;
            end else begin
              state_next = DONE;
            end
          end
        end
      end
      DONE: begin
        busy_next = 1'b0;
        if (end_reg && !iGO) begin
          end_next   = 1'b0;
          state_next = IDLE;
        end else begin
          end_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    {scl_next, sda_low_next} = bus_pins(state_next, phase_next, shift_next[23]);
  end

  assign oEND     = end_reg;
  assign oACK     = ack_reg;
  assign oBUSY    = busy_reg;
  assign I2C_SCLK = scl_reg;
  assign I2C_SDAT = sda_low_reg ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_byte_writer.sv
// Bench for i2c_byte_writer: slave/monitor model on the bus plus vector table.
`timescale 1ns/1ps
module tb_i2c_byte_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [23:0] data = '0;
  logic        o_end, o_ack, o_busy, scl;
  wire         sda;
  logic        slave_low = 1'b0;
  logic [2:0]  nack_mask = 3'b000;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_byte_writer #(.CLK_Freq(400), .I2C_Freq(20)) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iGO      (go),
    .iDATA    (data),
    .oEND     (o_end),
    .oACK     (o_ack),
    .oBUSY    (o_busy),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave, sampled on the falling clock edge.
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  int          bit_pos = 0;
  int          start_cnt = 0;
  int          stop_cnt = 0;
  int          glitch_cnt = 0;
  int          drive1_cnt = 0;
  logic [26:0] rx_sr = '0;

  always @(negedge clk) begin
    prev_scl <= scl;
    prev_sda <= sda;
    if (rst) begin
      bit_pos   <= 0;
      slave_low <= 1'b0;
    end else begin
      if (prev_scl && scl && (sda != prev_sda)) begin
        if (!sda) begin
          start_cnt <= start_cnt + 1;
          bit_pos   <= 0;
          rx_sr     <= '0;
          if (!(bit_pos == 1 || bit_pos >= 28)) glitch_cnt <= glitch_cnt + 1;
        end else if (bit_pos == 28) begin
          stop_cnt <= stop_cnt + 1;
        end else begin
          glitch_cnt <= glitch_cnt + 1;
        end
      end else if (!prev_scl && scl) begin
        if (bit_pos < 27) rx_sr <= {rx_sr[25:0], sda};
        if (bit_pos < 29) bit_pos <= bit_pos + 1;
      end else if (prev_scl && !scl) begin
        slave_low <= (bit_pos == 8  && !nack_mask[0]) ||
                     (bit_pos == 17 && !nack_mask[1]) ||
                     (bit_pos == 26 && !nack_mask[2]);
      end
      if (slave_low && sda !== 1'b0) drive1_cnt <= drive1_cnt + 1;
    end
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Raise iGO with a command and wait for oEND (or abort with reset at rst_at).
  task automatic run_xfer(input logic [23:0] d, input logic [2:0] nk,
                          input int poke_at, input int rst_at, output int lat);
    nack_mask = nk;
    @(negedge clk);
    data = d;
    go = 1'b1;
    @(posedge clk);
    #1;
    check("busy_on_accept", {31'd0, o_busy}, 32'd1);
    lat = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #1;
      if (n == poke_at) data = 24'hFFFFFF;
      if (n == rst_at) begin
        rst = 1'b1;
        go = 1'b0;
        #1;
        check("rst_scl", {31'd0, scl}, 32'd1);
        check("rst_sda", {31'd0, sda}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_end", {31'd0, o_end}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (o_end) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drop_go();
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check("end_falls", {31'd0, o_end}, 32'd0);
  endtask

  typedef struct {
    logic [23:0] cmd;
    logic [2:0]  nack;
    logic [7:0]  b0, b1, b2;
    logic        exp_ack;
  } vec_t;

  vec_t vecs [5];
  int   lat;
  int   s0, p0;

  initial begin
    vecs[0] = '{24'h340E41, 3'b000, 8'h34, 8'h0E, 8'h41, 1'b0};
    vecs[1] = '{24'h340E41, 3'b010, 8'h34, 8'h0E, 8'h41, 1'b1};
    vecs[2] = '{24'h001A1A, 3'b000, 8'h00, 8'h1A, 8'h1A, 1'b0};
    vecs[3] = '{24'hA5FF00, 3'b001, 8'hA5, 8'hFF, 8'h00, 1'b1};
    vecs[4] = '{24'hFFFFFF, 3'b111, 8'hFF, 8'hFF, 8'hFF, 1'b1};

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_scl", {31'd0, scl}, 32'd1);
    check("reset_sda", {31'd0, sda}, 32'd1);
    check("reset_end", {31'd0, o_end}, 32'd0);
    check("reset_ack", {31'd0, o_ack}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      s0 = start_cnt;
      p0 = stop_cnt;
      run_xfer(vecs[i].cmd, vecs[i].nack, 0, 0, lat);
      $display("vector %0d: cmd=%06h nack=%03b latency=%0d oACK=%0b bus=%02h %02h %02h",
               i, vecs[i].cmd, vecs[i].nack, lat, o_ack, rx_sr[26:19], rx_sr[17:10], rx_sr[8:1]);
      check("latency", 32'(lat), 32'd581);
      check("oack", {31'd0, o_ack}, {31'd0, vecs[i].exp_ack});
      check("busy_at_end", {31'd0, o_busy}, 32'd0);
      check("bus_bytes", {8'd0, rx_sr[26:19], rx_sr[17:10], rx_sr[8:1]},
            {8'd0, vecs[i].b0, vecs[i].b1, vecs[i].b2});
      check("ack_slots", {29'd0, rx_sr[18], rx_sr[9], rx_sr[0]},
            {29'd0, vecs[i].nack[0], vecs[i].nack[1], vecs[i].nack[2]});
      check("start_seen", 32'(start_cnt - s0), 32'd1);
      check("stop_seen", 32'(stop_cnt - p0), 32'd1);
      drop_go();
    end

    // iGO held high after completion must not retransmit.
    run_xfer(24'h340E41, 3'b000, 0, 0, lat);
    check("hold_latency", 32'(lat), 32'd581);
    s0 = start_cnt;
    repeat (2000) @(posedge clk);
    #1;
    check("hold_no_restart", 32'(start_cnt - s0), 32'd0);
    check("hold_end_high", {31'd0, o_end}, 32'd1);
    drop_go();
    run_xfer(24'h001A1A, 3'b000, 0, 0, lat);
    check("after_hold_latency", 32'(lat), 32'd581);
    check("after_hold_bytes", {8'd0, rx_sr[26:19], rx_sr[17:10], rx_sr[8:1]}, 32'h001A1A);
    drop_go();

    // iDATA changing while busy is ignored.
    run_xfer(24'h340E41, 3'b000, 100, 0, lat);
    check("poke_latency", 32'(lat), 32'd581);
    check("poke_bytes", {8'd0, rx_sr[26:19], rx_sr[17:10], rx_sr[8:1]}, 32'h340E41);
    drop_go();

    // Reset in the middle of the second byte, then a clean transfer.
    run_xfer(24'h340E41, 3'b000, 0, 200, lat);
    check("abort_no_end", 32'(lat), 32'hFFFFFFFF);
    repeat (3) @(posedge clk);
    s0 = start_cnt;
    p0 = stop_cnt;
    run_xfer(24'h340E41, 3'b000, 0, 0, lat);
    check("post_rst_latency", 32'(lat), 32'd581);
    check("post_rst_bytes", {8'd0, rx_sr[26:19], rx_sr[17:10], rx_sr[8:1]}, 32'h340E41);
    check("post_rst_stop", 32'(stop_cnt - p0), 32'd1);
    drop_go();

    repeat (5) @(posedge clk);
    check("sda_change_while_scl_high", 32'(glitch_cnt), 32'd0);
    check("sda_driven_high", 32'(drive1_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
